switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_pkg.sv | 25 ++
 rtl/switch_debouncer_channel.sv | 68 ++++++
 rtl/switch_debouncer.sv | 32 +++
 tb/tb_switch_debouncer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch debouncer.
// The default settle time is derived from the master clock rate and the debounce period.
package switch_debouncer_pkg;

    localparam int unsigned CLK_FREQ_HZ           = 100_000_000;
    localparam int unsigned DEBOUNCE_MS           = 10;
    localparam int unsigned STABLE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Change reported on the debounced level during the previous clock edge.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    // The settle counter only has to reach cycles-1.
    // Clamp the width to 1 so that an illegal depth still elaborates far enough to report its own error.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One debounced switch channel: two-flop synchronizer, settle counter and edge strobes.
// The output follows the synchronized input only after STABLE_CYCLES consecutive disagreeing cycles.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_depth
            $error("debounce_channel: STABLE_CYCLES must be at least 2");
        end
    endgenerate

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sw;
    logic [CNT_W-1:0] r_cnt;
    edge_e            r_edge;

    logic             w_differ;
    logic             w_settled;

    assign w_differ  = (r_sync2 != r_sw);
    assign w_settled = w_differ && (r_cnt == CNT_LAST);

    // The count clears on agreement or on acceptance, so it never passes CNT_LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sw    <= 1'b0;
            r_cnt   <= '0;
            r_edge  <= EDGE_NONE;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;

            if (!w_differ || w_settled) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_settled) begin
                r_sw   <= r_sync2;
                r_edge <= r_sync2 ? EDGE_RISE : EDGE_FALL;
            end else begin
                r_edge <= EDGE_NONE;
            end
        end
    end

    assign o_sw   = r_sw;
    assign o_rise = (r_edge == EDGE_RISE);
    assign o_fall = (r_edge == EDGE_FALL);

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce_channel instances.
// Debounced levels feed the downstream reset, shift_sel and func_sel controls.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_chan
            debounce_channel #(
                .STABLE_CYCLES(STABLE_CYCLES)
            ) u_chan (
                .clk    (clk),
                .reset  (reset),
                .i_sw   (sw_in[g]),
                .o_sw   (sw_out[g]),
                .o_rise (rise_pulse[g]),
                .o_fall (fall_pulse[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=3, STABLE_CYCLES=4): a window-based model predicts every cycle.
// Directed scenarios are followed by randomized switch bounce and reset activity.
module tb_switch_debouncer;

    localparam int W = 3;
    localparam int S = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] r;
        logic [W-1:0] f;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // hist[k] is the input level sampled k edges ago; the settled level seen at this edge is hist[2].
    function automatic void model_reset();
        m_out = '0;
        hist.delete();
        for (int k = 0; k < S + 2; k++) hist.push_back('0);
    endfunction

    initial model_reset();

    // A channel flips when the input, delayed by the two synchronizer edges, has disagreed with the output for S edges in a row.
    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (!reset) begin
            model_reset();
        end else begin
            hist.push_front(sw_in);
            void'(hist.pop_back());
            for (int c = 0; c < W; c++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 2; k < S + 2; k++) begin
                    if (hist[k][c] == m_out[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_out[c] = ~m_out[c];
                    if (m_out[c]) e.r[c] = 1'b1;
                    else          e.f[c] = 1'b1;
                end
            end
            e.o = m_out;
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_sw_out", sw_out, e.o);
            check("sb_rise", rise_pulse, e.r);
            check("sb_fall", fall_pulse, e.f);
        end
    end

    // Counts edges (from the last negedge drive) until the masked outputs match; -1 on timeout.
    task automatic edges_until(input logic [W-1:0] mask, input logic [W-1:0] val, output int n);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            n++;
            if ((sw_out & mask) == (val & mask)) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        logic [W-1:0] seen;
        int hold[W];

        // Reset held with all switches pressed.
        sw_in = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_sw_out", sw_out, 3'b000);
        check("rst_rise", rise_pulse, 3'b000);
        check("rst_fall", fall_pulse, 3'b000);
        reset = 1'b1;
        edges_until(3'b111, 3'b111, n);
        check_int("release_latency", n, S + 2);
        check("release_rise", rise_pulse, 3'b111);
        @(posedge clk); #1;
        check("release_rise_once", rise_pulse, 3'b000);

        // Clean fall on channel 2.
        @(negedge clk);
        sw_in[2] = 1'b0;
        edges_until(3'b100, 3'b000, n);
        check_int("fall2_latency", n, S + 2);
        check("fall2_fall", fall_pulse, 3'b100);
        check("fall2_rise", rise_pulse, 3'b000);

        // Bounce on channel 1 from a settled 0.
        @(negedge clk);
        sw_in[1] = 1'b0;
        edges_until(3'b010, 3'b000, n);
        check_int("ch1_low_latency", n, S + 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sw_in[1] = (i % 2 == 0);
            @(negedge clk);
        end
        check("bounce_hold", sw_out & 3'b010, 3'b000);
        @(negedge clk);
        sw_in[1] = 1'b1;
        edges_until(3'b010, 3'b010, n);
        check_int("bounce_settle", n, S + 2);

        // Short glitch on channel 0.
        @(negedge clk);
        sw_in[0] = 1'b0;
        edges_until(3'b001, 3'b000, n);
        check_int("ch0_low_latency", n, S + 2);
        @(negedge clk);
        sw_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        sw_in[0] = 1'b0;
        seen = '0;
        repeat (12) begin
            @(posedge clk); #1;
            seen[0] = seen[0] | sw_out[0] | rise_pulse[0] | fall_pulse[0];
        end
        check("glitch_ignored", seen, 3'b000);

        // Reset mid-count on channel 0.
        @(negedge clk);
        sw_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_out", sw_out, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        edges_until(3'b001, 3'b001, n);
        check_int("rst_midcount_latency", n, S + 2);

        // Opposite simultaneous changes on channels 0 and 2.
        @(negedge clk);
        sw_in = 3'b110;
        edges_until(3'b101, 3'b100, n);
        check_int("swap_a_latency", n, S + 2);
        @(negedge clk);
        sw_in = 3'b011;
        edges_until(3'b101, 3'b001, n);
        check_int("swap_b_latency", n, S + 2);
        check("swap_b_rise", rise_pulse, 3'b001);
        check("swap_b_fall", fall_pulse, 3'b100);

        // Randomized bounce with occasional reset pulses.
        for (int c = 0; c < W; c++) hold[c] = 0;
        repeat (3000) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset = 1'b0;
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    sw_in[c] = 1'($urandom_range(0, 1));
                    hold[c]  = $urandom_range(1, 2 * S + 3);
                end else begin
                    hold[c]--;
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
